// File: rtl/serial_addsub_arbiter_pkg.sv
// Shared constants and types for the serial add/subtract arbiter.
//   SLICES_DEF : default number of 3-bit slices (operand width 3*SLICES)
//   SLICE_W    : width of the shared add/sub slice
//   state_e    : top-level FSM state encoding
//   REQ_ID0/1  : requester identifiers used by the arbiter pointer
package serial_addsub_arbiter_pkg;

  localparam int SLICES_DEF = 4;
  localparam int SLICE_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/serial_addsub_arbiter_slice.sv
// addsub_slice3: combinational 3-bit adder with explicit carry-in.
// Subtraction is handled by the caller (inverted A, carry-in of 1).
//   a, b : 3-bit addends
//   cin  : carry in
//   s    : 3-bit sum
//   cout : carry out
module addsub_slice3
  import serial_addsub_arbiter_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] sum_full;

  assign sum_full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  assign s        = sum_full[SLICE_W-1:0];
  assign cout     = sum_full[SLICE_W];

endmodule

// File: rtl/serial_addsub_arbiter.sv
// serial_addsub_arbiter: two requesters share one 3-bit add/sub slice that
// is run slice-serially to compute B+A or B-A on 3*SLICES-bit operands.
//   clk, rst          : clock, synchronous active-high reset
//   req0/1            : requests (held until granted)
//   a0,b0,sub0 / a1.. : operands and operation select per requester
//   gnt0/1            : one-cycle grant pulse, operands captured at that edge
//   done0/1           : one-cycle completion pulse to the owner
//   busy              : high whenever the FSM is not idle
//   result,cout,ovf   : last completed result, final carry, signed overflow
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; arbitrates and latches operands
// RUN   | one slice per cycle, carry registered between slices
// DONE  | result/cout/ovf valid, done pulse to owner, back to IDLE
module serial_addsub_arbiter
  import serial_addsub_arbiter_pkg::*;
#(
  parameter int SLICES = SLICES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic [3*SLICES-1:0]     a0,
  input  logic [3*SLICES-1:0]     b0,
  input  logic                    sub0,
  input  logic                    req1,
  input  logic [3*SLICES-1:0]     a1,
  input  logic [3*SLICES-1:0]     b1,
  input  logic                    sub1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    done0,
  output logic                    done1,
  output logic                    busy,
  output logic [3*SLICES-1:0]     result,
  output logic                    cout,
  output logic                    ovf
);

  localparam int W     = SLICE_W * SLICES;
  localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     asm_q, asm_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             busy_q, busy_d;

  logic [SLICE_W-1:0] sum_s;
  logic               sum_c;

  logic               pick;
  logic               sub_sel;
  logic [W-1:0]       a_sel;
  logic [W-1:0]       b_sel;

  addsub_slice3 u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .s    (sum_s),
    .cout (sum_c)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    asm_d    = asm_q;
    owner_d  = owner_q;
    last_d   = last_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    pick     = REQ_ID0;
    sub_sel  = 1'b0;
    a_sel    = '0;
    b_sel    = '0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // On a tie, serve whoever was not served last.
          if (req0 && req1) pick = ~last_q;
          else              pick = req1 ? REQ_ID1 : REQ_ID0;

          sub_sel = (pick == REQ_ID1) ? sub1 : sub0;
          a_sel   = (pick == REQ_ID1) ? a1   : a0;
          b_sel   = (pick == REQ_ID1) ? b1   : b0;

          a_d     = a_sel ^ {W{sub_sel}};
          b_d     = b_sel;
          // sub doubles as the carry-in of slice 0.
          carry_d = sub_sel;
          idx_d   = '0;
          owner_d = pick;
          last_d  = pick;
          gnt0_d  = (pick == REQ_ID0);
          gnt1_d  = (pick == REQ_ID1);
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_d   = a_q >> SLICE_W;
        b_d   = b_q >> SLICE_W;
        asm_d = asm_q >> SLICE_W;
        asm_d[W-1 -: SLICE_W] = sum_s;
        carry_d = sum_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          result_d = asm_d;
          cout_d   = sum_c;
          // Operands have been shifted down to the top slice, so bit 2 of
          // the operand registers holds the original sign bits here.
          ovf_d    = (a_q[SLICE_W-1] == b_q[SLICE_W-1]) &&
                     (sum_s[SLICE_W-1] != a_q[SLICE_W-1]);
          done0_d  = (owner_q == REQ_ID0);
          done1_d  = (owner_q == REQ_ID1);
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      asm_q    <= '0;
      owner_q  <= REQ_ID0;
      last_q   <= REQ_ID1;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      asm_q    <= asm_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign busy   = busy_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
